// File: rtl/dmi_async_queue_source.sv
// Source half of the DMI clock-domain crossing: register FIFO with Gray write index and synchronized read index.
// Optional reset-safety handshake with the sink is enabled by defining DMI_XING_SAFE_EN.
module dmi_async_queue_source #(
    parameter int unsigned DATA_W      = 41,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned SYNC_STAGES = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enq_valid,
    output logic                      enq_ready,
    input  logic [DATA_W-1:0]         enq_bits,
    output logic [DEPTH*DATA_W-1:0]   async_mem,
    output logic [$clog2(DEPTH):0]    async_widx,
    input  logic [$clog2(DEPTH):0]    async_ridx,
    output logic                      async_widx_valid,
    input  logic                      async_ridx_valid,
    output logic                      async_source_reset_n,
    input  logic                      async_sink_reset_n
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned IW = AW + 1;
    // Full when the write Gray index equals the read Gray index with its top two bits inverted.
    localparam logic [IW-1:0] FULL_MASK = IW'(3) << (IW - 2);

    logic [IW-1:0]                   wbin_q, wbin_d;
    logic [IW-1:0]                   widx_q, widx_d;
    logic                            enq_ready_q, enq_ready_d;
    logic [DEPTH-1:0][DATA_W-1:0]    mem_q, mem_d;
    logic [SYNC_STAGES-1:0][IW-1:0]  ridx_sync_q, ridx_sync_d;
    logic [IW-1:0]                   ridx_s;
    logic                            sink_ok;
    logic                            fire;
    logic                            unused_sink_reset_n;

    function automatic logic [IW-1:0] bin2gray(input logic [IW-1:0] b);
        return b ^ (b >> 1);
    endfunction

`ifdef DMI_XING_SAFE_EN
    logic [SYNC_STAGES-1:0] rvalid_sync_q, rvalid_sync_d;
    logic [SYNC_STAGES-1:0] alive_q, alive_d;

    // Sink-alive synchronizer and source-alive shift chain.
    always_comb begin
        rvalid_sync_d = {rvalid_sync_q[SYNC_STAGES-2:0], async_ridx_valid};
        alive_d       = {alive_q[SYNC_STAGES-2:0], 1'b1};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rvalid_sync_q <= '0;
            alive_q       <= '0;
        end else begin
            rvalid_sync_q <= rvalid_sync_d;
            alive_q       <= alive_d;
        end
    end

    assign sink_ok          = rvalid_sync_q[SYNC_STAGES-1];
    assign async_widx_valid = alive_q[SYNC_STAGES-1];
`else
    logic alive_q;
    logic unused_ridx_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
        end
    end

    assign sink_ok           = 1'b1;
    assign async_widx_valid  = alive_q;
    assign unused_ridx_valid = async_ridx_valid;
`endif

    // Read-index synchronizer.
    always_comb begin
        ridx_sync_d = {ridx_sync_q[SYNC_STAGES-2:0], async_ridx};
    end

    assign ridx_s = ridx_sync_q[SYNC_STAGES-1];

    // Enqueue, write pointer and ready evaluated against the post-fire pointer.
    always_comb begin
        fire   = enq_valid & enq_ready_q;
        mem_d  = mem_q;
        wbin_d = wbin_q;
        if (fire) begin
            mem_d[wbin_q[AW-1:0]] = enq_bits;
            wbin_d                = wbin_q + IW'(1);
        end
        if (!sink_ok) begin
            wbin_d = '0;
        end
        widx_d      = bin2gray(wbin_d);
        enq_ready_d = sink_ok && (widx_d != (ridx_s ^ FULL_MASK));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wbin_q      <= '0;
            widx_q      <= '0;
            enq_ready_q <= 1'b0;
            mem_q       <= '0;
            ridx_sync_q <= '0;
        end else begin
            wbin_q      <= wbin_d;
            widx_q      <= widx_d;
            enq_ready_q <= enq_ready_d;
            mem_q       <= mem_d;
            ridx_sync_q <= ridx_sync_d;
        end
    end

    assign enq_ready            = enq_ready_q;
    assign async_widx           = widx_q;
    assign async_mem            = mem_q;
    assign async_source_reset_n = ~reset;
    assign unused_sink_reset_n  = async_sink_reset_n;

endmodule

// File: tb/tb_dmi_async_queue_source.sv
// Bench for dmi_async_queue_source: randomized enqueue/dequeue against an occupancy/latency model.
module tb_dmi_async_queue_source;

    localparam int unsigned DATA_W = 41;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned SYNC   = 3;
    localparam int unsigned IW     = 4;
`ifdef DMI_XING_SAFE_EN
    localparam int READY_LAT = SYNC + 1;
    localparam int VALID_LAT = SYNC;
`else
    localparam int READY_LAT = 1;
    localparam int VALID_LAT = 1;
`endif

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic                    enq_valid = 1'b0;
    logic                    enq_ready;
    logic [DATA_W-1:0]       enq_bits = '0;
    logic [DEPTH*DATA_W-1:0] async_mem;
    logic [IW-1:0]           async_widx;
    logic [IW-1:0]           async_ridx = '0;
    logic                    async_widx_valid;
    logic                    async_ridx_valid = 1'b1;
    logic                    async_source_reset_n;
    logic                    async_sink_reset_n = 1'b1;

    dmi_async_queue_source #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clock(clock), .reset(reset), .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_bits(enq_bits), .async_mem(async_mem), .async_widx(async_widx),
        .async_ridx(async_ridx), .async_widx_valid(async_widx_valid),
        .async_ridx_valid(async_ridx_valid), .async_source_reset_n(async_source_reset_n),
        .async_sink_reset_n(async_sink_reset_n)
    );

    always #5 clock = ~clock;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference model: counts of writes/reads and per-edge history of sink-side inputs.
    int                edge_n;
    int                wcount;
    int                rcount;
    bit                exp_ready;
    logic [DATA_W-1:0] mem_model [DEPTH];
    logic [DATA_W-1:0] exp_q [$];
    int                rc_at [4096];
    bit                v_at  [4096];

    function automatic logic [IW-1:0] gray(input int c);
        logic [IW-1:0] b;
        b = IW'(c);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [DATA_W-1:0] mem_entry(input int i);
        return async_mem[i*DATA_W +: DATA_W];
    endfunction

    function automatic bit sink_ok_model(input int n);
`ifdef DMI_XING_SAFE_EN
        return (n > int'(SYNC)) && v_at[n-int'(SYNC)];
`else
        return (n >= 0);
`endif
    endfunction

    function automatic bit exp_widx_valid();
        return edge_n >= VALID_LAT;
    endfunction

    task automatic model_clear();
        edge_n    = 0;
        wcount    = 0;
        rcount    = 0;
        exp_ready = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) mem_model[i] = '0;
        exp_q.delete();
    endtask

    task automatic tick();
        bit f;
        bit ok;
        int seen;
        f = enq_valid && exp_ready;
        if (edge_n + 1 < 4096) begin
            rc_at[edge_n+1] = rcount;
            v_at[edge_n+1]  = async_ridx_valid;
        end
        @(posedge clock);
        #1;
        if (edge_n < 4095) edge_n++;
        ok = sink_ok_model(edge_n);
        if (f) begin
            mem_model[wcount % int'(DEPTH)] = enq_bits;
            exp_q.push_back(enq_bits);
            wcount++;
        end
        if (!ok) wcount = 0;
        seen      = (edge_n > int'(SYNC)) ? rc_at[edge_n-int'(SYNC)] : 0;
        exp_ready = ok && ((wcount - seen) < int'(DEPTH));
    endtask

    task automatic test_reset();
        int first_rdy;
        first_rdy        = -1;
        reset            = 1'b1;
        enq_valid        = 1'b0;
        enq_bits         = '0;
        async_ridx       = '0;
        async_ridx_valid = 1'b1;
        #2;
        chk_cnt++; if (enq_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", enq_ready); else pass_cnt++;
        chk_cnt++; if (async_widx !== 4'd0) $display("FAIL reset_widx got=%0d exp=0", async_widx); else pass_cnt++;
        chk_cnt++; if (async_widx_valid !== 1'b0) $display("FAIL reset_widx_valid got=%b exp=0", async_widx_valid); else pass_cnt++;
        chk_cnt++; if (async_source_reset_n !== 1'b0) $display("FAIL reset_src_rst_n got=%b exp=0", async_source_reset_n); else pass_cnt++;
        chk_cnt++; if (async_mem !== '0) $display("FAIL reset_mem got=%h exp=0", async_mem); else pass_cnt++;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_clear();
        #1;
        chk_cnt++; if (async_source_reset_n !== 1'b1) $display("FAIL release_src_rst_n got=%b exp=1", async_source_reset_n); else pass_cnt++;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk_cnt++; if (enq_ready !== exp_ready) $display("FAIL idle_ready edge=%0d got=%b exp=%b", i, enq_ready, exp_ready); else pass_cnt++;
            chk_cnt++; if (async_widx_valid !== exp_widx_valid()) $display("FAIL idle_widx_valid edge=%0d got=%b exp=%b", i, async_widx_valid, exp_widx_valid()); else pass_cnt++;
            chk_cnt++; if (async_widx !== 4'd0) $display("FAIL idle_widx edge=%0d got=%0d exp=0", i, async_widx); else pass_cnt++;
            if (enq_ready === 1'b1 && first_rdy < 0) first_rdy = i;
        end
        chk_cnt++; if (first_rdy != READY_LAT) $display("FAIL first_ready_edge got=%0d exp=%0d", first_rdy, READY_LAT); else pass_cnt++;
    endtask

    task automatic test_fill();
        logic [3:0] gtab [8];
        gtab = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};
        for (int i = 0; i < 8; i++) begin
            enq_valid = 1'b1;
            enq_bits  = DATA_W'(32'h100 + i);
            tick();
            chk_cnt++; if (async_widx !== gtab[i]) $display("FAIL fill_widx i=%0d got=%0d exp=%0d", i, async_widx, gtab[i]); else pass_cnt++;
            chk_cnt++; if (enq_ready !== exp_ready) $display("FAIL fill_ready i=%0d got=%b exp=%b", i, enq_ready, exp_ready); else pass_cnt++;
        end
        chk_cnt++; if (enq_ready !== 1'b0) $display("FAIL full_ready got=%b exp=0", enq_ready); else pass_cnt++;
        enq_bits = DATA_W'(32'hABC);
        tick();
        enq_valid = 1'b0;
        chk_cnt++; if (async_widx !== 4'd12) $display("FAIL full_hold_widx got=%0d exp=12", async_widx); else pass_cnt++;
        chk_cnt++; if (mem_entry(0) !== DATA_W'(32'h100)) $display("FAIL full_no_write got=%h exp=100", mem_entry(0)); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            chk_cnt++;
            if (mem_entry(i) !== DATA_W'(32'h100 + i)) $display("FAIL fill_mem i=%0d got=%h exp=%h", i, mem_entry(i), 32'h100 + i);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        chk_cnt++; if (mem_entry(0) !== e) $display("FAIL bp_pop got=%h exp=%h", mem_entry(0), e); else pass_cnt++;
        rcount     = 1;
        async_ridx = gray(rcount);
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk_cnt++; if (enq_ready !== exp_ready) $display("FAIL bp_ready edge=%0d got=%b exp=%b", i, enq_ready, exp_ready); else pass_cnt++;
            if (enq_ready === 1'b1) begin
                n = i;
                break;
            end
        end
        chk_cnt++; if (n != int'(SYNC) + 1) $display("FAIL bp_latency got=%0d exp=%0d", n, SYNC + 1); else pass_cnt++;
        enq_valid = 1'b1;
        enq_bits  = DATA_W'(32'h1AA);
        tick();
        enq_valid = 1'b0;
        chk_cnt++; if (mem_entry(0) !== DATA_W'(32'h1AA)) $display("FAIL bp_push_mem got=%h exp=1aa", mem_entry(0)); else pass_cnt++;
        chk_cnt++; if (async_widx !== 4'd13) $display("FAIL bp_push_widx got=%0d exp=13", async_widx); else pass_cnt++;
        chk_cnt++; if (enq_ready !== exp_ready) $display("FAIL bp_refull got=%b exp=%b", enq_ready, exp_ready); else pass_cnt++;
    endtask

    task automatic test_stream();
        int n_push;
        int cyc;
        bit saw_wrap;
        logic [IW-1:0] prev_widx;
        logic [DATA_W-1:0] e;
        n_push    = 0;
        cyc       = 0;
        saw_wrap  = 1'b0;
        prev_widx = async_widx;
        while (n_push < 40 && cyc < 2000) begin
            enq_valid = ($urandom_range(0, 3) != 0);
            enq_bits  = DATA_W'({$urandom, $urandom});
            if (enq_valid && exp_ready) n_push++;
            tick();
            cyc++;
            chk_cnt++; if (enq_ready !== exp_ready) $display("FAIL stream_ready cyc=%0d got=%b exp=%b", cyc, enq_ready, exp_ready); else pass_cnt++;
            chk_cnt++; if (async_widx !== gray(wcount)) $display("FAIL stream_widx cyc=%0d got=%0d exp=%0d", cyc, async_widx, gray(wcount)); else pass_cnt++;
            if (prev_widx == 4'd8 && async_widx != 4'd8) begin
                saw_wrap = 1'b1;
                chk_cnt++; if (async_widx !== 4'd0) $display("FAIL stream_wrap got=%0d exp=0", async_widx); else pass_cnt++;
            end
            prev_widx = async_widx;
            if ($urandom_range(0, 1) == 1 && wcount > rcount && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk_cnt++; if (mem_entry(rcount % int'(DEPTH)) !== e) $display("FAIL stream_data r=%0d got=%h exp=%h", rcount, mem_entry(rcount % int'(DEPTH)), e); else pass_cnt++;
                rcount++;
                async_ridx = gray(rcount);
            end
        end
        enq_valid = 1'b0;
        chk_cnt++; if (n_push != 40) $display("FAIL stream_count got=%0d exp=40", n_push); else pass_cnt++;
        chk_cnt++; if (saw_wrap !== 1'b1) $display("FAIL stream_saw_wrap got=%b exp=1", saw_wrap); else pass_cnt++;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            chk_cnt++; if (mem_entry(rcount % int'(DEPTH)) !== e) $display("FAIL drain_data r=%0d got=%h exp=%h", rcount, mem_entry(rcount % int'(DEPTH)), e); else pass_cnt++;
            rcount++;
            async_ridx = gray(rcount);
            tick();
        end
        for (int i = 0; i < int'(SYNC) + 1; i++) tick();
        chk_cnt++; if (enq_ready !== 1'b1) $display("FAIL drain_ready got=%b exp=1", enq_ready); else pass_cnt++;
    endtask

`ifdef DMI_XING_SAFE_EN
    task automatic test_sink_loss();
        enq_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            enq_bits = DATA_W'(32'h300 + i);
            tick();
        end
        enq_valid        = 1'b0;
        async_ridx_valid = 1'b0;
        rcount           = 0;
        async_ridx       = '0;
        exp_q.delete();
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk_cnt++; if (enq_ready !== exp_ready) $display("FAIL loss_ready edge=%0d got=%b exp=%b", i, enq_ready, exp_ready); else pass_cnt++;
            chk_cnt++; if (async_widx !== gray(wcount)) $display("FAIL loss_widx edge=%0d got=%0d exp=%0d", i, async_widx, gray(wcount)); else pass_cnt++;
            if (i == 4) begin
                chk_cnt++; if (async_widx !== 4'd0 || enq_ready !== 1'b0) $display("FAIL loss_forced widx=%0d ready=%b exp=0/0", async_widx, enq_ready); else pass_cnt++;
            end
        end
        chk_cnt++;
        if (mem_entry(wcount % int'(DEPTH)) !== mem_model[wcount % int'(DEPTH)]) $display("FAIL loss_mem_kept got=%h exp=%h", mem_entry(0), mem_model[0]);
        else pass_cnt++;
        async_ridx_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_cnt++; if (enq_ready !== exp_ready) $display("FAIL recover_ready edge=%0d got=%b exp=%b", i, enq_ready, exp_ready); else pass_cnt++;
        end
        chk_cnt++; if (enq_ready !== 1'b1) $display("FAIL recover_ready4 got=%b exp=1", enq_ready); else pass_cnt++;
        enq_valid = 1'b1;
        enq_bits  = DATA_W'(32'h3FF);
        tick();
        enq_valid = 1'b0;
        chk_cnt++; if (async_widx !== 4'd1) $display("FAIL recover_widx got=%0d exp=1", async_widx); else pass_cnt++;
        chk_cnt++; if (mem_entry(0) !== DATA_W'(32'h3FF)) $display("FAIL recover_mem got=%h exp=3ff", mem_entry(0)); else pass_cnt++;
    endtask
`else
    task automatic test_ridx_valid_ignored();
        async_ridx_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_cnt++; if (enq_ready !== exp_ready) $display("FAIL ignore_ready edge=%0d got=%b exp=%b", i, enq_ready, exp_ready); else pass_cnt++;
            chk_cnt++; if (async_widx !== gray(wcount)) $display("FAIL ignore_widx edge=%0d got=%0d exp=%0d", i, async_widx, gray(wcount)); else pass_cnt++;
        end
        async_ridx_valid = 1'b1;
    endtask
`endif

    task automatic test_reset_full();
        enq_valid = 1'b1;
        for (int i = 0; i < 20 && exp_ready; i++) begin
            enq_bits = DATA_W'({$urandom, $urandom}) | DATA_W'(1);
            tick();
            chk_cnt++; if (enq_ready !== exp_ready) $display("FAIL refill_ready got=%b exp=%b", enq_ready, exp_ready); else pass_cnt++;
        end
        enq_valid = 1'b0;
        chk_cnt++; if (enq_ready !== 1'b0) $display("FAIL refill_full got=%b exp=0", enq_ready); else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        chk_cnt++; if (enq_ready !== 1'b0) $display("FAIL midrst_ready got=%b exp=0", enq_ready); else pass_cnt++;
        chk_cnt++; if (async_widx !== 4'd0) $display("FAIL midrst_widx got=%0d exp=0", async_widx); else pass_cnt++;
        chk_cnt++; if (async_mem !== '0) $display("FAIL midrst_mem got=%h exp=0", async_mem); else pass_cnt++;
        chk_cnt++; if (async_source_reset_n !== 1'b0) $display("FAIL midrst_src_rst_n got=%b exp=0", async_source_reset_n); else pass_cnt++;
        chk_cnt++; if (async_widx_valid !== 1'b0) $display("FAIL midrst_widx_valid got=%b exp=0", async_widx_valid); else pass_cnt++;
        @(posedge clock);
        #1;
        chk_cnt++; if (async_source_reset_n !== 1'b0) $display("FAIL midrst_hold_src_rst_n got=%b exp=0", async_source_reset_n); else pass_cnt++;
        reset      = 1'b0;
        async_ridx = '0;
        model_clear();
        for (int i = 1; i <= READY_LAT; i++) begin
            tick();
            chk_cnt++; if (enq_ready !== exp_ready) $display("FAIL postrst_ready edge=%0d got=%b exp=%b", i, enq_ready, exp_ready); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_backpressure();
        test_stream();
`ifdef DMI_XING_SAFE_EN
        test_sink_loss();
`else
        test_ridx_valid_ignored();
`endif
        test_reset_full();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

endmodule
